// File: rtl/led_pwm_pkg.sv
// Shared register map and bus helpers for the LED PWM bank.
package led_pwm_pkg;

    localparam int ADDR_CTRL         = 0;
    localparam int ADDR_BLINK_EN     = 1;
    localparam int ADDR_BLINK_PERIOD = 2;
    localparam int ADDR_STATUS       = 3;
    localparam int ADDR_DUTY_BASE    = 4;

    localparam int CTRL_GLOBAL_EN    = 31;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: glitch-free shadowed duty and PWM compare.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                global_en,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] shadow_d, shadow_q;

    // While globally disabled the shadow tracks DUTY so enabling starts cleanly.
    always_comb begin
        shadow_d = shadow_q;
        if (!global_en || period_end) shadow_d = duty;
    end

    always_ff @(posedge clk) begin
        if (reset) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end

    assign pwm_on = (&shadow_q) ? 1'b1 : (pwm_cnt < shadow_q);

endmodule

// File: rtl/led_pwm_bank.sv
// Avalon-MM LED bank: per-channel PWM duty, enable and blink on a shared timebase.
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS     = 5,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE_DIV = 196,
    parameter int ADDR_W       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic                AVL_CS,
    input  logic [3:0]          AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]   AVL_ADDR,
    input  logic [31:0]         AVL_WRITEDATA,
    output logic [31:0]         AVL_READDATA,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int PRESC_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [31:0] CTRL_MASK = (32'h1 << CTRL_GLOBAL_EN) | ((32'h1 << NUM_LEDS) - 32'h1);

    logic [31:0]                        ctrl_d, ctrl_q;
    logic [NUM_LEDS-1:0]                blink_en_d, blink_en_q;
    logic [15:0]                        blink_period_d, blink_period_q;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty_d, duty_q;
    logic [PRESC_W-1:0]                 presc_d, presc_q;
    logic [PWM_BITS-1:0]                pwm_cnt_d, pwm_cnt_q;
    logic [15:0]                        blink_cnt_d, blink_cnt_q;
    logic                               phase_d, phase_q;
    logic [NUM_LEDS-1:0]                leds_d, leds_q;
    logic [NUM_LEDS-1:0]                pwm_on;
    logic [31:0]                        blink_en_m, blink_period_m, duty_m;
    logic                               wr_en, bp_wr, tick, period_end;
    logic                               unused_read;

    assign unused_read = AVL_READ;
    assign wr_en       = AVL_CS & AVL_WRITE;

    always_comb begin
        ctrl_d         = ctrl_q;
        blink_en_d     = blink_en_q;
        blink_period_d = blink_period_q;
        duty_d         = duty_q;
        bp_wr          = 1'b0;
        blink_en_m     = be_merge({{(32-NUM_LEDS){1'b0}}, blink_en_q}, AVL_WRITEDATA, AVL_BYTE_EN);
        blink_period_m = be_merge({16'h0, blink_period_q}, AVL_WRITEDATA, AVL_BYTE_EN);
        duty_m         = '0;
        if (wr_en) begin
            if (AVL_ADDR == ADDR_W'(ADDR_CTRL))
                ctrl_d = be_merge(ctrl_q, AVL_WRITEDATA, AVL_BYTE_EN) & CTRL_MASK;
            if (AVL_ADDR == ADDR_W'(ADDR_BLINK_EN))
                blink_en_d = blink_en_m[NUM_LEDS-1:0];
            if (AVL_ADDR == ADDR_W'(ADDR_BLINK_PERIOD)) begin
                blink_period_d = blink_period_m[15:0];
                bp_wr          = 1'b1;
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (AVL_ADDR == ADDR_W'(ADDR_DUTY_BASE + i)) begin
                    duty_m    = be_merge({{(32-PWM_BITS){1'b0}}, duty_q[i]}, AVL_WRITEDATA, AVL_BYTE_EN);
                    duty_d[i] = duty_m[PWM_BITS-1:0];
                end
            end
        end
    end

    // Shared timebase: prescaler -> PWM counter -> blink half-cycle counter.
    always_comb begin
        tick        = (presc_q == PRESC_W'(PRESCALE_DIV - 1));
        presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        period_end  = tick & (&pwm_cnt_q);
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (period_end) begin
            if (blink_period_q == 16'd0) begin
                blink_cnt_d = '0;
                phase_d     = 1'b1;
            end else if (blink_cnt_q == blink_period_q - 16'd1) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
        if (bp_wr) blink_cnt_d = '0;
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .duty       (duty_q[g]),
            .period_end (period_end),
            .pwm_cnt    (pwm_cnt_q),
            .global_en  (ctrl_q[CTRL_GLOBAL_EN]),
            .pwm_on     (pwm_on[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++)
            leds_d[i] = ctrl_q[CTRL_GLOBAL_EN] & ctrl_q[i] & (blink_en_q[i] ? phase_q : 1'b1) & pwm_on[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q         <= '0;
            blink_en_q     <= '0;
            blink_period_q <= '0;
            duty_q         <= '0;
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            blink_cnt_q    <= '0;
            phase_q        <= 1'b1;
            leds_q         <= '0;
        end else begin
            ctrl_q         <= ctrl_d;
            blink_en_q     <= blink_en_d;
            blink_period_q <= blink_period_d;
            duty_q         <= duty_d;
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
            leds_q         <= leds_d;
        end
    end

    assign leds = leds_q;

    always_comb begin
        AVL_READDATA = '0;
        if (AVL_CS) begin
            if (AVL_ADDR == ADDR_W'(ADDR_CTRL))         AVL_READDATA = ctrl_q;
            if (AVL_ADDR == ADDR_W'(ADDR_BLINK_EN))     AVL_READDATA[NUM_LEDS-1:0] = blink_en_q;
            if (AVL_ADDR == ADDR_W'(ADDR_BLINK_PERIOD)) AVL_READDATA[15:0] = blink_period_q;
            if (AVL_ADDR == ADDR_W'(ADDR_STATUS)) begin
                AVL_READDATA[0]             = phase_q;
                AVL_READDATA[8 +: PWM_BITS] = pwm_cnt_q;
            end
            for (int i = 0; i < NUM_LEDS; i++)
                if (AVL_ADDR == ADDR_W'(ADDR_DUTY_BASE + i)) AVL_READDATA[PWM_BITS-1:0] = duty_q[i];
        end
    end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed bench for led_pwm_bank with a 1-cycle prescaler and 4-bit PWM (16-cycle period).
module tb_led_pwm_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]  AVL_BYTE_EN;
    logic [3:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA, AVL_READDATA;
    logic [4:0]  leds;

    int checks = 0;
    int errors = 0;

    led_pwm_bank #(.NUM_LEDS(5), .PWM_BITS(4), .PRESCALE_DIV(1), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
        AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        @(negedge clk);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = a;
        #1 d = AVL_READDATA;
    endtask

    // One cycle: STATUS and leds sampled just after the falling edge.
    task automatic smp(output logic [31:0] st, output logic [4:0] l);
        @(negedge clk);
        AVL_WRITE = 1'b0;
        rd(4'd3, st);
        l = leds;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b1;
        AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
        AVL_ADDR = '0; AVL_WRITEDATA = '0; AVL_BYTE_EN = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (leds !== 5'b0) begin errors++; $display("FAIL reset_leds got %h want 00", leds); end
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d);
            checks++;
            if (d !== ((a == 3) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL reset_read addr %0d got %h want %h", a, d, (a == 3) ? 32'h1 : 32'h0);
            end
        end
        AVL_CS = 1'b0; AVL_ADDR = 4'd3;
        #1 checks++;
        if (AVL_READDATA !== 32'h0) begin errors++; $display("FAIL read_no_cs got %h want 0", AVL_READDATA); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_byte_en;
        logic [31:0] d;
        logic [31:0] st;
        logic [4:0]  l;
        wr(4'd0, 32'hAABBCCDD, 4'b0001);
        rd(4'd0, d);
        // Only CTRL bits [4:0] exist below bit 31, so 0xDD reads back as 0x1D.
        checks++;
        if (d !== 32'h0000001D) begin errors++; $display("FAIL byte_en_ctrl got %h want 0000001d", d); end
        for (int k = 0; k < 20; k++) begin
            smp(st, l);
            checks++;
            if (l !== 5'b0) begin errors++; $display("FAIL byte_en_leds got %h want 00", l); end
        end
    endtask

    task automatic test_duty_levels;
        logic [31:0] st;
        logic [4:0]  l;
        logic [3:0]  cp;
        int          hi [3];
        wr(4'd4, 32'd0, 4'hF);
        wr(4'd5, 32'd4, 4'hF);
        wr(4'd6, 32'd15, 4'hF);
        wr(4'd0, 32'h8000001F, 4'hF);
        repeat (20) @(negedge clk);
        hi = '{0, 0, 0};
        for (int k = 0; k < 16; k++) begin
            smp(st, l);
            cp = st[11:8] - 4'd1;
            for (int j = 0; j < 3; j++) hi[j] += int'(l[j]);
            checks++;
            if (l[2:0] !== {1'b1, cp < 4'd4, 1'b0}) begin
                errors++; $display("FAIL duty_lag cnt_prev %0d got %b want %b", cp, l[2:0], {1'b1, cp < 4'd4, 1'b0});
            end
        end
        checks++;
        if (hi[0] != 0 || hi[1] != 4 || hi[2] != 16) begin
            errors++; $display("FAIL duty_count got %0d/%0d/%0d want 0/4/16", hi[0], hi[1], hi[2]);
        end
    endtask

    task automatic test_mid_period;
        logic [31:0] st;
        logic [4:0]  l;
        logic [3:0]  cp;
        logic [3:0]  sh;
        int          n;
        int          hi_next;
        n = 0;
        do begin smp(st, l); n++; end while (st[11:8] != 4'd2 && n < 40);
        checks++;
        if (st[11:8] != 4'd2) begin errors++; $display("FAIL mid_wait got cnt %0d want 2", st[11:8]); end
        AVL_WRITE = 1'b1; AVL_READ = 1'b0; AVL_ADDR = 4'd5;
        AVL_WRITEDATA = 32'd8; AVL_BYTE_EN = 4'hF;
        sh = 4'd4; hi_next = 0;
        for (int k = 0; k < 30; k++) begin
            smp(st, l);
            cp = st[11:8] - 4'd1;
            if (cp == 4'd0) sh = 4'd8;
            if (sh == 4'd8) hi_next += int'(l[1]);
            checks++;
            if (l[1] !== (cp < sh)) begin
                errors++; $display("FAIL mid_period cnt_prev %0d got %b want %b", cp, l[1], cp < sh);
            end
        end
        checks++;
        if (hi_next != 8) begin errors++; $display("FAIL mid_next_count got %0d want 8", hi_next); end
    endtask

    task automatic test_blink;
        logic [31:0] st;
        logic [4:0]  l;
        logic        prev;
        int          n;
        int          run;
        wr(4'd5, 32'd15, 4'hF);
        wr(4'd1, 32'h2, 4'hF);
        wr(4'd2, 32'd2, 4'hF);
        repeat (40) @(negedge clk);
        smp(st, l); prev = l[1]; n = 0;
        do begin smp(st, l); n++; end while (l[1] == prev && n < 80);
        for (int r = 0; r < 2; r++) begin
            prev = l[1]; run = 1;
            do begin
                smp(st, l);
                checks++;
                if (l[2] !== 1'b1 || l[0] !== 1'b0) begin
                    errors++; $display("FAIL blink_others got %b want 1x0", l[2:0]);
                end
                if (l[1] == prev) run++;
            end while (l[1] == prev && run < 80);
            checks++;
            if (run != 32) begin errors++; $display("FAIL blink_run %0d got %0d want 32", r, run); end
        end
        n = 0; prev = l[1];
        do begin prev = l[1]; smp(st, l); n++; end while (!(prev == 1'b1 && l[1] == 1'b0) && n < 80);
        checks++;
        if (!(prev == 1'b1 && l[1] == 1'b0)) begin errors++; $display("FAIL blink_fall got %b want 0", l[1]); end
        AVL_WRITE = 1'b1; AVL_READ = 1'b0; AVL_ADDR = 4'd2;
        AVL_WRITEDATA = 32'd0; AVL_BYTE_EN = 4'hF;
        smp(st, l);
        checks++;
        if (l[1] !== 1'b0) begin errors++; $display("FAIL blink_off_hold got %b want 0", l[1]); end
        repeat (15) smp(st, l);
        for (int k = 0; k < 40; k++) begin
            smp(st, l);
            checks++;
            if (l[1] !== 1'b1) begin errors++; $display("FAIL blink_inert cycle %0d got %b want 1", k, l[1]); end
        end
    endtask

    task automatic test_unmapped_reset;
        logic [31:0] d;
        logic [31:0] st;
        logic [4:0]  l;
        logic [31:0] exp_rd [16];
        int          n;
        exp_rd = '{32'h8000001F, 32'h2, 32'h0, 32'h0, 32'h0, 32'hF, 32'hF, 32'h0,
                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        wr(4'd15, 32'h1, 4'hF);
        for (int a = 0; a < 16; a++) begin
            if (a == 3) continue;
            rd(4'(a), d);
            checks++;
            if (d !== exp_rd[a]) begin errors++; $display("FAIL unmapped_read addr %0d got %h want %h", a, d, exp_rd[a]); end
        end
        n = 0;
        do begin smp(st, l); n++; end while (st[11:8] != 4'd7 && n < 40);
        reset = 1'b1;
        smp(st, l);
        checks++;
        if (l !== 5'b0) begin errors++; $display("FAIL reset_mid_leds got %h want 00", l); end
        checks++;
        if (st !== 32'h1) begin errors++; $display("FAIL reset_mid_status got %h want 00000001", st); end
        reset = 1'b0;
        smp(st, l);
        checks++;
        if (st[11:8] !== 4'd1) begin errors++; $display("FAIL reset_restart got cnt %0d want 1", st[11:8]); end
        rd(4'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_byte_en();
        test_duty_levels();
        test_mid_period();
        test_blink();
        test_unmapped_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
